// File: rtl/e203_irq_stim_sched_if.sv
// Stimulus-scheduler bus: commit-trace inputs and interrupt/status outputs.
// The scheduler takes the slave modport and the environment takes the master modport.
interface e203_irq_stim_sched_if #(
    parameter int PC_W = 32
) ();
    logic            enable;
    logic            cmt_valid;
    logic [PC_W-1:0] cmt_pc;
    logic            irq_ext;
    logic            irq_sft;
    logic            irq_tmr;
    logic [31:0]     tohost_cnt;
    logic            armed;
    logic            quiet;
    logic            finish;
    logic [2:0]      tmo_err;

    modport master (
        output enable, cmt_valid, cmt_pc,
        input  irq_ext, irq_sft, irq_tmr, tohost_cnt, armed, quiet, finish, tmo_err
    );

    modport slave (
        input  enable, cmt_valid, cmt_pc,
        output irq_ext, irq_sft, irq_tmr, tohost_cnt, armed, quiet, finish, tmo_err
    );
endinterface

// File: rtl/e203_irq_stim_sched.sv
// Interrupt-stimulus scheduler: three independent channels assert ext/sft/tmr after
// pseudo-random delays and hold each line until its handler's pre-MRET commit is seen.
module e203_irq_stim_ch #(
    parameter logic [15:0] ACK_TMO = 16'd4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       armed,
    input  logic       enable,
    input  logic       stop,
    input  logic       ack,
    input  logic [9:0] dly,
    output logic       irq,
    output logic       tmo
);
    typedef enum logic [1:0] {IDLE, WAIT, ASSERT, DONE} st_t;

    st_t         st, st_nx;
    logic [9:0]  cnt, cnt_nx;
    logic [15:0] wd, wd_nx;
    logic        irq_nx, tmo_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st  <= IDLE;
            cnt <= '0;
            wd  <= '0;
            irq <= 1'b0;
            tmo <= 1'b0;
        end else begin
            st  <= st_nx;
            cnt <= cnt_nx;
            wd  <= wd_nx;
            irq <= irq_nx;
            tmo <= tmo_nx;
        end
    end

    // The counter holds D-1 and fires at zero, so a 10-bit counter covers D = 1..1024
    // while irq still rises exactly D cycles after WAIT entry.
    always_comb begin
        st_nx  = st;
        cnt_nx = cnt;
        wd_nx  = wd;
        irq_nx = 1'b0;
        tmo_nx = tmo;
        unique case (st)
            IDLE: begin
                if (armed && enable && !stop) begin
                    st_nx  = WAIT;
                    cnt_nx = dly;
                end
            end
            WAIT: begin
                if (!enable) begin
                    st_nx = IDLE;
                end else if (stop) begin
                    st_nx = DONE;
                end else if (cnt == '0) begin
                    st_nx  = ASSERT;
                    irq_nx = 1'b1;
                    wd_nx  = '0;
                end else begin
                    cnt_nx = cnt - 10'd1;
                end
            end
            ASSERT: begin
                irq_nx = 1'b1;
                if (ack || wd == ACK_TMO - 16'd1) begin
                    irq_nx = 1'b0;
                    if (!ack) tmo_nx = 1'b1;
                    if (stop) begin
                        st_nx = DONE;
                    end else if (!enable) begin
                        st_nx = IDLE;
                    end else begin
                        st_nx  = WAIT;
                        cnt_nx = dly;
                    end
                end else begin
                    wd_nx = wd + 16'd1;
                end
            end
            default: ;
        endcase
    end
endmodule

module e203_irq_stim_sched #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] START_PC   = 32'h8000015C,
    parameter logic [PC_W-1:0] TOHOST_PC  = 32'h80000086,
    parameter logic [PC_W-1:0] ACK_PC_EXT = 32'h800000A6,
    parameter logic [PC_W-1:0] ACK_PC_SFT = 32'h800000BE,
    parameter logic [PC_W-1:0] ACK_PC_TMR = 32'h800000D6,
    parameter logic [31:0]     STOP_CNT   = 32'd32,
    parameter logic [31:0]     FINISH_CNT = 32'd8,
    parameter logic [9:0]      DLY_MASK   = 10'h3FF,
    parameter logic [15:0]     ACK_TMO    = 16'd4096,
    parameter logic [15:0]     LFSR_SEED  = 16'hACE1
) (
    input logic                  clk,
    input logic                  rst_n,
    e203_irq_stim_sched_if.slave bus
);
    localparam int NCH = 3;
    localparam logic [NCH-1:0][PC_W-1:0] ACK_PCS = {ACK_PC_TMR, ACK_PC_SFT, ACK_PC_EXT};

    logic [15:0]          lfsr;
    logic [31:0]          cnt_q;
    logic                 armed_q;
    logic                 stop;
    logic [NCH-1:0][9:0]  dly;
    logic [NCH-1:0]       ack;
    logic [NCH-1:0]       irq;
    logic [NCH-1:0]       tmo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr    <= LFSR_SEED;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            if (bus.cmt_valid && bus.cmt_pc == TOHOST_PC && cnt_q != '1)
                cnt_q <= cnt_q + 32'd1;
            if (bus.cmt_valid && bus.enable && bus.cmt_pc == START_PC)
                armed_q <= 1'b1;
        end
    end

    assign stop = cnt_q > STOP_CNT;

    // Distinct LFSR windows keep the three channels' delays decorrelated.
    assign dly[0] = lfsr[9:0] & DLY_MASK;
    assign dly[1] = lfsr[14:5] & DLY_MASK;
    assign dly[2] = {lfsr[3:0], lfsr[15:10]} & DLY_MASK;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ack[i] = bus.cmt_valid && bus.cmt_pc == ACK_PCS[i];
        e203_irq_stim_ch #(.ACK_TMO(ACK_TMO)) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .armed  (armed_q),
            .enable (bus.enable),
            .stop   (stop),
            .ack    (ack[i]),
            .dly    (dly[i]),
            .irq    (irq[i]),
            .tmo    (tmo[i])
        );
    end

    assign bus.irq_ext    = irq[0];
    assign bus.irq_sft    = irq[1];
    assign bus.irq_tmr    = irq[2];
    assign bus.tohost_cnt = cnt_q;
    assign bus.armed      = armed_q;
    assign bus.tmo_err    = tmo;
    assign bus.quiet      = ~|irq;
    assign bus.finish     = (cnt_q >= FINISH_CNT) && ~|irq;
endmodule
